// File: rtl/trigger_word_sequencer.sv
// Programmable trigger-word table feeding an OSERDES2 parallel input; one word per trigger event.
// Optional TRIGGER_HOLDOFF_EN adds post-emission dead time with missed-trigger accounting.
module trigger_word_sequencer #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned PERIOD_LOG2    = 24,
   parameter int unsigned HOLDOFF_CYCLES = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       self_triggered_mode,
   input  logic                       trigger_input,
   input  logic                       table_write_enable,
   input  logic [$clog2(DEPTH)-1:0]   table_write_address,
   input  logic [WIDTH-1:0]           table_write_data,
   input  logic [$clog2(DEPTH)-1:0]   sequence_last,
   output logic [WIDTH-1:0]           word,
   output logic                       sync,
   output logic [$clog2(DEPTH)-1:0]   token,
   output logic [15:0]                missed_trigger_count
);

   localparam int unsigned TW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF_CYCLES == 0) begin : g_bad_param
      $error("trigger_word_sequencer: DEPTH must be a power of two >= 2 and HOLDOFF_CYCLES >= 1");
   end

   // Reset contents: entry 0 is upper-half ones, others carry MSB plus their index.
   function automatic logic [WIDTH-1:0] default_entry(input int unsigned idx);
      logic [WIDTH-1:0] w;
      if (idx == 0) begin
         w = {{(WIDTH - WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}};
      end else begin
         w            = WIDTH'(idx);
         w[WIDTH-1]   = 1'b1;
      end
      return w;
   endfunction

   logic [WIDTH-1:0]       table_q [DEPTH];
   logic [2:0]             stream_q, stream_d;
   logic [PERIOD_LOG2-1:0] period_q, period_d;
   logic [TW-1:0]          token_q, token_d;
   logic [WIDTH-1:0]       word_q, word_d;
   logic                   sync_q, sync_d;
   logic                   event_c;
   logic                   emit_c;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            table_q[i] <= default_entry(i);
         end
      end else if (table_write_enable) begin
         table_q[table_write_address] <= table_write_data;
      end
   end

   assign event_c = self_triggered_mode ? (period_q == '0) : (stream_q == 3'b001);

`ifdef TRIGGER_HOLDOFF_EN
   localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);

   logic [HW-1:0] holdoff_q, holdoff_d;
   logic [15:0]   missed_q, missed_d;

   assign emit_c = event_c && (holdoff_q == '0);

   // Dead-time counter and saturating drop counter.
   always_comb begin
      holdoff_d = holdoff_q;
      missed_d  = missed_q;
      if (emit_c) begin
         holdoff_d = HW'(HOLDOFF_CYCLES - 1);
      end else if (holdoff_q != '0) begin
         holdoff_d = holdoff_q - HW'(1);
      end
      if (event_c && !emit_c && missed_q != 16'hFFFF) begin
         missed_d = missed_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         holdoff_q <= '0;
         missed_q  <= '0;
      end else begin
         holdoff_q <= holdoff_d;
         missed_q  <= missed_d;
      end
   end

   assign missed_trigger_count = missed_q;
`else
   assign emit_c               = event_c;
   assign missed_trigger_count = 16'h0000;
`endif

   always_comb begin
      stream_d = {stream_q[1:0], trigger_input};
      period_d = period_q + PERIOD_LOG2'(1);
      token_d  = token_q;
      word_d   = '0;
      sync_d   = 1'b0;
      if (emit_c) begin
         word_d  = table_q[token_q];
         sync_d  = (token_q == '0);
         token_d = (token_q >= sequence_last) ? '0 : token_q + TW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         stream_q <= '0;
         period_q <= '0;
         token_q  <= '0;
         word_q   <= '0;
         sync_q   <= 1'b0;
      end else begin
         stream_q <= stream_d;
         period_q <= period_d;
         token_q  <= token_d;
         word_q   <= word_d;
         sync_q   <= sync_d;
      end
   end

   assign word  = word_q;
   assign sync  = sync_q;
   assign token = token_q;

endmodule
